// File: rtl/rps_round_controller.sv
// Rock-paper-scissors round controller: freezes the computer chooser, waits for it to settle, judges, scores.
// Optional match mode (first to WIN_SCORE, then OVER until new_match) is enabled by defining RPS_MATCH_EN.
module rps_round_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIN_SCORE     = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] player_choice,
  input  logic       player_valid,
  input  logic [1:0] computer_choice,
  input  logic       new_match,
  output logic       stop_signal,
  output logic       busy,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [3:0] player_score,
  output logic [3:0] computer_score,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, LOCK, SETTLE, RETRY, JUDGE, OVER} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] player_p0;
  logic [1:0] computer_p0;
  logic [3:0] settle_cnt;
  logic [1:0] verdict;
  logic [3:0] player_next;
  logic [3:0] computer_next;

  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
    if (p == c) return 2'd3;
    if ((p == 2'd1 && c == 2'd3) || (p == 2'd2 && c == 2'd1) || (p == 2'd3 && c == 2'd2))
      return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  always_comb begin
    verdict       = judge(player_p0, computer_p0);
    player_next   = sat_inc(player_score);
    computer_next = sat_inc(computer_score);
  end

`ifdef RPS_MATCH_EN
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
`else
  logic unused_cfg;
  assign unused_cfg = new_match ^ (WIN_SCORE == 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      player_p0      <= 2'd0;
      computer_p0    <= 2'd0;
      settle_cnt     <= 4'd0;
      stop_signal    <= 1'b0;
      busy           <= 1'b0;
      result         <= 2'd0;
      result_valid   <= 1'b0;
      player_score   <= 4'd0;
      computer_score <= 4'd0;
      game_over      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef RPS_MATCH_EN
          if (new_match) begin
            player_score   <= 4'd0;
            computer_score <= 4'd0;
            game_over      <= 1'b0;
          end else
`endif
          if (player_valid && player_choice != 2'd0) begin
            player_p0   <= player_choice;
            state       <= LOCK;
            stop_signal <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOCK: begin
          state       <= SETTLE;
          settle_cnt  <= 4'd0;
          stop_signal <= 1'b1;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            // A zero choice means the chooser latched nothing; release it for one cycle and relock.
            if (computer_choice != 2'd0) begin
              computer_p0 <= computer_choice;
              state       <= JUDGE;
            end else begin
              state       <= RETRY;
              stop_signal <= 1'b0;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RETRY: begin
          state       <= LOCK;
          stop_signal <= 1'b1;
        end
        JUDGE: begin
          result       <= verdict;
          result_valid <= 1'b1;
          stop_signal  <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
          if (verdict == 2'd1) player_score <= player_next;
          if (verdict == 2'd2) computer_score <= computer_next;
`ifdef RPS_MATCH_EN
          if ((verdict == 2'd1 && player_next == WIN) || (verdict == 2'd2 && computer_next == WIN)) begin
            game_over <= 1'b1;
            state     <= OVER;
          end
`endif
        end
        OVER: begin
`ifdef RPS_MATCH_EN
          if (new_match) begin
            player_score   <= 4'd0;
            computer_score <= 4'd0;
            game_over      <= 1'b0;
            state          <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
